mio_bus_responder: RTL and testbench

- Responder end of the CPU memory/IO bus.
- Accepts requests from the single-cycle CPU: strobe, address, write data, write enable.
- Decodes each request to block RAM, LED/switch GPIO, a down-counter timer or the interrupt control register.
- Returns read data with a one-cycle `mio_ready` pulse, and drives the CPU interrupt line from latched timer and external-button events.

---
 rtl/mio_pkg.sv | 17 +
 rtl/mio_timer.sv | 17 +
 rtl/mio_bus_responder.sv | 114 +++++++++++
 tb/tb_mio_bus_responder.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mio_pkg.sv
// mio_pkg: address map, region and FSM encodings, and interrupt bit indices shared by the MIO responder.
package mio_pkg;
  localparam logic [31:0] RAM_BASE   = 32'h0000_0000;
  localparam logic [31:0] GPIO_ADDR  = 32'hE000_0000;
  localparam logic [31:0] TIMER_ADDR = 32'hF000_0000;
  localparam logic [31:0] INTC_ADDR  = 32'hF000_0004;
  localparam int IRQ_TIMER = 0;
  localparam int IRQ_EXT   = 1;
  typedef enum logic [2:0] {RGN_NONE, RGN_RAM, RGN_GPIO, RGN_TIMER, RGN_INTC} region_e;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;
  function automatic region_e decode(input logic [31:0] a);
    return a[31:28] == RAM_BASE[31:28] ? RGN_RAM :
           a == GPIO_ADDR  ? RGN_GPIO  :
           a == TIMER_ADDR ? RGN_TIMER :
           a == INTC_ADDR  ? RGN_INTC  : RGN_NONE;
  endfunction
endpackage

// File: rtl/mio_timer.sv
// mio_timer: 32-bit loadable down-counter with a pulse on the 1->0 step; a load suppresses that pulse.
module mio_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_i,
  input  logic [31:0] load_val_i,
  output logic [31:0] count_o,
  output logic        zero_o
);
  logic [31:0] count_q;
  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else count_q <= load_i ? load_val_i : count_q - 32'(count_q != 32'd0);
  end
  assign count_o = count_q;
  assign zero_o  = !load_i && count_q == 32'd1;
endmodule

// File: rtl/mio_bus_responder.sv
// mio_bus_responder: responder end of the CPU MIO bus decoding RAM, GPIO, timer and interrupt control,
// answering each request with a one-cycle mio_ready pulse and driving the CPU interrupt line.
module mio_bus_responder
  import mio_pkg::*;
#(
  parameter int RAM_AW   = 10,
  parameter int RAM_WAIT = 1,
  parameter int GPIO_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_mio,
  input  logic              mem_w,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              mio_ready,
  output logic              intr,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_we,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  input  logic [GPIO_W-1:0] sw,
  output logic [GPIO_W-1:0] led,
  input  logic              ext_irq
);
  state_e            state_q;
  region_e           rgn;
  logic [1:0]        wcnt_q, pend_q, en_q, pend_d, en_d, irq_set;
  logic [31:0]       rdata_q, ram_wdata_q, rd_val, tmr_count;
  logic [RAM_AW-1:0] ram_addr_q;
  logic [GPIO_W-1:0] led_q;
  logic              rd_ram_q, ram_we_q, intr_q, ext_q;
  logic              wr, tmr_load, tmr_zero, intc_wr, ram_rd;

  assign rgn      = decode(addr);
  assign wr       = state_q == S_IDLE && cpu_mio && mem_w;
  assign tmr_load = wr && rgn == RGN_TIMER;
  assign intc_wr  = wr && rgn == RGN_INTC;
  assign ram_rd   = rgn == RGN_RAM && !mem_w;

  mio_timer u_timer (
    .clk       (clk),
    .reset     (reset),
    .load_i    (tmr_load),
    .load_val_i(wdata),
    .count_o   (tmr_count),
    .zero_o    (tmr_zero)
  );

  // New events are OR-ed in after the clear so a set always beats a same-cycle clear.
  always_comb begin
    irq_set            = '0;
    irq_set[IRQ_TIMER] = tmr_zero;
    irq_set[IRQ_EXT]   = ext_irq && !ext_q;
    pend_d = (pend_q & ~(intc_wr ? wdata[1:0] : 2'b00)) | irq_set;
    en_d   = intc_wr ? wdata[3:2] : en_q;
    rd_val = rgn == RGN_GPIO  ? 32'(sw) :
             rgn == RGN_TIMER ? tmr_count :
             rgn == RGN_INTC  ? {28'b0, en_q, pend_q} : 32'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wcnt_q      <= '0;
      rd_ram_q    <= 1'b0;
      rdata_q     <= '0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      led_q       <= '0;
      pend_q      <= '0;
      en_q        <= '0;
      intr_q      <= 1'b0;
      ext_q       <= 1'b0;
    end else begin
      ext_q    <= ext_irq;
      pend_q   <= pend_d;
      en_q     <= en_d;
      intr_q   <= |(pend_d & en_d);
      ram_we_q <= 1'b0;
      case (state_q)
        S_IDLE: if (cpu_mio) begin
          rd_ram_q <= ram_rd;
          rdata_q  <= mem_w ? 32'b0 : rd_val;
          ram_we_q <= mem_w && rgn == RGN_RAM;
          if (rgn == RGN_RAM) ram_addr_q <= addr[RAM_AW+1:2];
          if (wr && rgn == RGN_RAM) ram_wdata_q <= wdata;
          if (wr && rgn == RGN_GPIO) led_q <= wdata[GPIO_W-1:0];
          wcnt_q  <= 2'(RAM_WAIT - 1);
          state_q <= ram_rd && RAM_WAIT != 0 ? S_WAIT : S_RESP;
        end
        S_WAIT: begin
          wcnt_q <= wcnt_q - 2'd1;
          if (wcnt_q == 2'd0) state_q <= S_RESP;
        end
        default: begin
          state_q  <= S_IDLE;
          rd_ram_q <= 1'b0;
        end
      endcase
    end
  end

  // RAM read data is forwarded straight from the RAM port during the response cycle.
  assign mio_ready = state_q == S_RESP;
  assign rdata     = mio_ready ? (rd_ram_q ? ram_rdata : rdata_q) : 32'b0;
  assign ram_addr  = ram_addr_q;
  assign ram_we    = ram_we_q;
  assign ram_wdata = ram_wdata_q;
  assign led       = led_q;
  assign intr      = intr_q;
endmodule

// File: tb/tb_mio_bus_responder.sv
// tb_mio_bus_responder: directed and randomized bus transactions checked against a behavioural model.
module tb_mio_bus_responder;
  localparam int RAM_AW = 10;
  localparam int GPIO_W = 16;
  localparam logic [31:0] GPIO_A = 32'hE000_0000;
  localparam logic [31:0] TMR_A  = 32'hF000_0000;
  localparam logic [31:0] INTC_A = 32'hF000_0004;

  logic clk = 1'b0, reset = 1'b1, cpu_mio = 1'b0, mem_w = 1'b0, ext_irq = 1'b0;
  logic [31:0] addr = '0, wdata = '0, ram_rdata = '0;
  logic [GPIO_W-1:0] sw = '0;
  logic [31:0] rdata, ram_wdata;
  logic mio_ready, intr, ram_we;
  logic [RAM_AW-1:0] ram_addr;
  logic [GPIO_W-1:0] led;

  int checks = 0, errors = 0, cyc = 0;
  logic [31:0] ram_mem [1024] = '{default: 32'h0};
  logic [31:0] mem_ref [1024] = '{default: 32'h0};
  logic [31:0] ld_val = '0;
  int ld_cyc = 0;
  logic [GPIO_W-1:0] led_ref = '0;

  logic [31:0] rd, a, d;
  int lat, t, k, idx;
  logic we1, w;
  logic [RAM_AW-1:0] ra1;

  mio_bus_responder #(.RAM_AW(RAM_AW), .RAM_WAIT(1), .GPIO_W(GPIO_W)) dut (
    .clk(clk), .reset(reset), .cpu_mio(cpu_mio), .mem_w(mem_w), .addr(addr), .wdata(wdata),
    .rdata(rdata), .mio_ready(mio_ready), .intr(intr), .ram_addr(ram_addr), .ram_we(ram_we),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .sw(sw), .led(led), .ext_irq(ext_irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read block RAM: data appears one edge after the registered address.
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_wdata;
    ram_rdata <= ram_mem[ram_addr];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Timer value seen by a read accepted at edge tt, from the last load's value and edge.
  function automatic logic [31:0] tmr_at(input int tt);
    longint el;
    el = longint'(tt) - 1 - longint'(ld_cyc);
    return el >= longint'(ld_val) ? 32'h0 : ld_val - 32'(el);
  endfunction

  task automatic xact(input logic wi, input logic [31:0] ai, input logic [31:0] di,
                      output logic [31:0] rdo, output int lato, output int to,
                      output logic weo, output logic [RAM_AW-1:0] rao);
    cpu_mio = 1'b1; mem_w = wi; addr = ai; wdata = di;
    @(posedge clk); #1;
    to = cyc; lato = 1; weo = ram_we; rao = ram_addr;
    while (!mio_ready && lato < 8) begin
      @(posedge clk); #1;
      lato++;
    end
    rdo = rdata;
    cpu_mio = 1'b0; mem_w = 1'b0;
    @(posedge clk); #1;
    chk(32'(mio_ready), 32'd0, "ready_one_cycle");
    chk(rdata, 32'd0, "rdata_idle_zero");
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk(32'(mio_ready), 0, "rst_ready");
    chk(rdata, 0, "rst_rdata");
    chk(32'(ram_we), 0, "rst_ram_we");
    chk(32'(ram_addr), 0, "rst_ram_addr");
    chk(ram_wdata, 0, "rst_ram_wdata");
    chk(32'(led), 0, "rst_led");
    chk(32'(intr), 0, "rst_intr");
    reset = 1'b0;

    xact(1'b1, GPIO_A, 32'h0000_00A5, rd, lat, t, we1, ra1);
    led_ref = 16'h00A5;
    chk(lat, 1, "gpio_wr_lat");
    chk(32'(led), 32'h00A5, "gpio_led");
    sw = 16'h1234;
    xact(1'b0, GPIO_A, 32'h0, rd, lat, t, we1, ra1);
    chk(lat, 1, "gpio_rd_lat");
    chk(rd, 32'h0000_1234, "gpio_rd");

    xact(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, rd, lat, t, we1, ra1);
    mem_ref[4] = 32'hDEAD_BEEF;
    chk(lat, 1, "ram_wr_lat");
    chk(32'(we1), 1, "ram_we_pulse");
    chk(32'(ra1), 4, "ram_wr_addr");
    xact(1'b0, 32'h0000_0010, 32'h0, rd, lat, t, we1, ra1);
    chk(lat, 2, "ram_rd_lat");
    chk(rd, 32'hDEAD_BEEF, "ram_rd");

    for (int i = 0; i < 80; i++) begin
      k = $urandom_range(0, 3);
      w = 1'($urandom_range(0, 1));
      d = $urandom;
      idx = $urandom_range(0, 1023);
      a = k == 0 ? {20'h0, 10'(idx), 2'($urandom_range(0, 3))} : k == 1 ? GPIO_A : k == 2 ? TMR_A :
          {4'($urandom_range(1, 13)), 28'($urandom)};
      if (k == 2 && w) d = $urandom_range(0, 40);
      sw = 16'($urandom);
      xact(w, a, d, rd, lat, t, we1, ra1);
      chk(lat, (k == 0 && !w) ? 2 : 1, "rnd_lat");
      chk(32'(we1), 32'(k == 0 && w), "rnd_ram_we");
      if (!w) chk(rd, k == 0 ? mem_ref[idx] : k == 1 ? 32'(sw) : k == 2 ? tmr_at(t) : 32'h0, "rnd_rd");
      else if (k == 0) begin
        mem_ref[idx] = d;
        chk(32'(ra1), idx, "rnd_ram_addr");
      end else if (k == 1) led_ref = d[15:0];
      else if (k == 2) begin
        ld_val = d;
        ld_cyc = t;
      end
      chk(32'(led), 32'(led_ref), "rnd_led");
    end

    repeat (64) @(posedge clk);
    #1;
    xact(1'b1, INTC_A, 32'h3, rd, lat, t, we1, ra1);
    xact(1'b0, INTC_A, 32'h0, rd, lat, t, we1, ra1);
    chk(rd, 32'h0, "intc_cleared");

    xact(1'b1, INTC_A, 32'hC, rd, lat, t, we1, ra1);
    xact(1'b1, TMR_A, 32'd3, rd, lat, t, we1, ra1);
    ld_val = 32'd3;
    ld_cyc = t;
    while (cyc < t + 2) begin
      @(posedge clk); #1;
    end
    chk(32'(intr), 0, "intr_before_zero");
    @(posedge clk); #1;
    chk(32'(intr), 1, "intr_timer");
    xact(1'b0, INTC_A, 32'h0, rd, lat, t, we1, ra1);
    chk(rd, 32'hD, "intc_timer_pend");
    xact(1'b1, INTC_A, 32'h1, rd, lat, t, we1, ra1);
    chk(32'(intr), 0, "intr_cleared");
    xact(1'b0, INTC_A, 32'h0, rd, lat, t, we1, ra1);
    chk(rd, 32'h0, "intc_after_w1c");

    xact(1'b1, INTC_A, 32'hC, rd, lat, t, we1, ra1);
    ext_irq = 1'b1;
    @(posedge clk); #1;
    ext_irq = 1'b0;
    chk(32'(intr), 1, "intr_ext");
    @(posedge clk); #1;
    ext_irq = 1'b1;
    xact(1'b1, INTC_A, 32'hE, rd, lat, t, we1, ra1);
    xact(1'b0, INTC_A, 32'h0, rd, lat, t, we1, ra1);
    chk(rd, 32'hE, "intc_set_wins");
    chk(32'(intr), 1, "intr_set_wins");
    ext_irq = 1'b0;
    xact(1'b1, INTC_A, 32'hE, rd, lat, t, we1, ra1);
    xact(1'b0, INTC_A, 32'h0, rd, lat, t, we1, ra1);
    chk(rd, 32'hC, "intc_ext_cleared");
    chk(32'(intr), 0, "intr_ext_cleared");

    xact(1'b1, TMR_A, 32'd1000, rd, lat, t, we1, ra1);
    ld_val = 32'd1000;
    ld_cyc = t;
    cpu_mio = 1'b1; mem_w = 1'b0; addr = TMR_A;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      chk(32'(mio_ready), i % 2, "b2b_ready");
      if (i % 2 == 1) chk(rdata, tmr_at(cyc), "b2b_rd");
    end
    cpu_mio = 1'b0;
    @(posedge clk); #1;
    xact(1'b0, 32'h8000_0000, 32'h0, rd, lat, t, we1, ra1);
    chk(lat, 1, "unmapped_lat");
    chk(rd, 32'h0, "unmapped_rd");
    xact(1'b1, 32'hE000_0008, 32'hFFFF, rd, lat, t, we1, ra1);
    chk(lat, 1, "unmapped_wr_lat");
    chk(32'(led), 32'(led_ref), "unmapped_wr_led");

    cpu_mio = 1'b1; mem_w = 1'b0; addr = 32'h0000_0010;
    @(posedge clk); #1;
    chk(32'(mio_ready), 0, "wait_no_ready");
    reset = 1'b1;
    cpu_mio = 1'b0;
    @(posedge clk); #1;
    chk(32'(mio_ready), 0, "mid_rst_ready");
    chk(rdata, 0, "mid_rst_rdata");
    chk(32'(ram_we), 0, "mid_rst_ram_we");
    chk(32'(ram_addr), 0, "mid_rst_ram_addr");
    chk(ram_wdata, 0, "mid_rst_ram_wdata");
    chk(32'(led), 0, "mid_rst_led");
    chk(32'(intr), 0, "mid_rst_intr");
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk(32'(mio_ready), 0, "post_rst_ready");
      chk(32'(ram_we), 0, "post_rst_ram_we");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
